// File: rtl/hex_display_scan_driver.sv
// Time-multiplexed 7-segment scan driver: shadowed hex word, per-digit blank/dp,
// leading-zero suppression and anode dead time; all pins driven straight from flops.
module hex_display_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 50000,
  parameter int DEAD_CYCLES = 2,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lzb_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [31:0]   DEAD_U    = 32'(DEAD_CYCLES);
  localparam logic          SEG_INV   = (SEG_ACT_LOW != 0);
  localparam logic          AN_INV    = (AN_ACT_LOW != 0);

  logic [CW-1:0]           slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] value_sh_q, value_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    slot_end;
  logic                    in_dead;
  logic                    lz_run;
  logic [NUM_DIGITS-1:0]   lz_zero;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_dark;
  logic [6:0]              seg_log;
  logic                    dp_log;
  logic [NUM_DIGITS-1:0]   an_log;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end   = (slot_cnt_q == SLOT_LAST);
    slot_cnt_d = slot_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_end) begin
      slot_cnt_d = '0;
      idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    value_sh_d = load ? value    : value_sh_q;
    dp_sh_d    = load ? dp_in    : dp_sh_q;
    blank_sh_d = load ? blank_in : blank_sh_q;
  end

  // lz_zero[i]: shadow digits i..NUM_DIGITS-1 are all zero
  always_comb begin
    lz_zero = '0;
    lz_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run     = lz_run & (value_sh_q[4*i +: 4] == 4'h0);
      lz_zero[i] = lz_run;
    end
  end

  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib  = value_sh_q[4*i +: 4];
        cur_dp   = dp_sh_q[i];
        cur_dark = blank_sh_q[i] | (lzb_en & (i > 0) & lz_zero[i]);
      end
    end
  end

  // Logical (active-high) view first; pin polarity is folded in just before the flops.
  always_comb begin
    in_dead      = (32'(slot_cnt_q) < DEAD_U);
    seg_log      = (in_dead | cur_dark) ? 7'h00 : hex_to_seg(cur_nib);
    dp_log       = ~(in_dead | cur_dark) & cur_dp;
    an_log       = in_dead ? '0 : (NUM_DIGITS'(1) << idx_q);
    seg_d        = seg_log ^ {7{SEG_INV}};
    dp_d         = dp_log ^ SEG_INV;
    an_d         = an_log ^ {NUM_DIGITS{AN_INV}};
    frame_tick_d = slot_end & (idx_q == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      value_sh_q   <= '0;
      dp_sh_q      <= '0;
      blank_sh_q   <= '0;
      seg_q        <= {7{SEG_INV}};
      dp_q         <= SEG_INV;
      an_q         <= {NUM_DIGITS{AN_INV}};
      frame_tick_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      value_sh_q   <= value_sh_d;
      dp_sh_q      <= dp_sh_d;
      blank_sh_q   <= blank_sh_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_display_scan_driver.sv
// Directed bench for hex_display_scan_driver: 4 digits, 4-cycle slots, 1 dead cycle, active-low pins.
module tb_hex_display_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lzb_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hex_display_scan_driver #(
    .NUM_DIGITS (4),
    .SLOT_CYCLES(4),
    .DEAD_CYCLES(1),
    .SEG_ACT_LOW(1),
    .AN_ACT_LOW (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .load      (load),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .lzb_en    (lzb_en),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_tick(frame_tick)
  );

  function automatic logic [6:0] seg_of(input int h);
    logic [6:0] s;
    case (h)
      0: s = 7'h7E;  1: s = 7'h30;  2: s = 7'h6D;  3: s = 7'h79;
      4: s = 7'h33;  5: s = 7'h5B;  6: s = 7'h5F;  7: s = 7'h70;
      8: s = 7'h7F;  9: s = 7'h7B;  10: s = 7'h77; 11: s = 7'h1F;
      12: s = 7'h4E; 13: s = 7'h3D; 14: s = 7'h4F; default: s = 7'h47;
    endcase
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dp), 32'h1);
    chk({tag, "_ft"}, 32'(frame_tick), 32'h0);
  endtask

  // Checks one 16-cycle frame starting with the digit-0 dead cycle.
  // segs = logical {d3,d2,d1,d0}; dps = logical dp per digit.
  // pre_load drives a load of nv coincident with the closing wrap edge.
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps,
                             input bit pre_load, input logic [15:0] nv);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (pre_load && d == 3 && c == 3) begin
          value = nv;
          load  = 1'b1;
        end
        step();
        load = 1'b0;
        if (c == 0) begin
          e_an  = 4'hF;
          e_seg = 7'h7F;
          e_dp  = 1'b1;
        end else begin
          e_an  = ~(4'b0001 << d);
          e_seg = ~segs[7*d +: 7];
          e_dp  = ~dps[d];
        end
        chk($sformatf("%s_an_d%0d_c%0d", tag, d, c), 32'(an), 32'(e_an));
        chk($sformatf("%s_seg_d%0d_c%0d", tag, d, c), 32'(seg), 32'(e_seg));
        chk($sformatf("%s_dp_d%0d_c%0d", tag, d, c), 32'(dp), 32'(e_dp));
        chk($sformatf("%s_ft_d%0d_c%0d", tag, d, c), 32'(frame_tick), 32'(d == 3 && c == 3));
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = 16'h0000;
    dp_in    = 4'h0;
    blank_in = 4'h0;
    lzb_en   = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle($sformatf("reset%0d", i));
    end

    // Release reset with a load on the same first edge.
    rst_n = 1'b1;
    value = 16'h1234;
    load  = 1'b1;
    check_frame("scan1", {7'h30, 7'h6D, 7'h79, 7'h33}, 4'h0, 1'b0, 16'h0);
    check_frame("scan2", {7'h30, 7'h6D, 7'h79, 7'h33}, 4'h0, 1'b0, 16'h0);

    for (int h = 0; h < 16; h++) begin
      value = 16'(h);
      load  = 1'b1;
      check_frame($sformatf("dec%0h", h), {7'h7E, 7'h7E, 7'h7E, seg_of(h)}, 4'h0, 1'b0, 16'h0);
    end

    value  = 16'h0050;
    lzb_en = 1'b1;
    load   = 1'b1;
    check_frame("lzb50", {7'h00, 7'h00, 7'h5B, 7'h7E}, 4'h0, 1'b0, 16'h0);
    value = 16'h0000;
    load  = 1'b1;
    check_frame("lzb0", {7'h00, 7'h00, 7'h00, 7'h7E}, 4'h0, 1'b0, 16'h0);
    lzb_en = 1'b0;
    check_frame("nolzb0", {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'h0, 1'b0, 16'h0);

    value    = 16'h1234;
    blank_in = 4'b0010;
    dp_in    = 4'b0001;
    load     = 1'b1;
    check_frame("blkdp", {7'h30, 7'h6D, 7'h00, 7'h33}, 4'b0001, 1'b0, 16'h0);

    // Load lands exactly on the frame wrap edge; old data until then, new data after.
    blank_in = 4'b0000;
    dp_in    = 4'b0000;
    check_frame("wrapld", {7'h30, 7'h6D, 7'h00, 7'h33}, 4'b0001, 1'b1, 16'hABCD);
    check_frame("newval", {7'h77, 7'h1F, 7'h4E, 7'h3D}, 4'h0, 1'b0, 16'h0);

    // One-cycle reset in the middle of digit 1's slot.
    for (int i = 0; i < 6; i++) step();
    chk("mid_an_before", 32'(an), 32'hD);
    rst_n = 1'b0;
    step();
    chk_idle("midrst");
    rst_n = 1'b1;
    check_frame("restart", {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'h0, 1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
